// File: rtl/rob_commit.sv
// Reorder buffer: allocates in-order tags, collects CDB results, retires one entry per cycle
// into the register-file commit port / store path, and raises a flush on a mispredicted branch.
module rob_commit #(
  parameter int ROB_SIZE_WIDTH = 3,
  parameter int REG_NUM_WIDTH  = 5
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      dec_valid,
  input  logic [1:0]                dec_type,
  input  logic [REG_NUM_WIDTH-1:0]  dec_rd,
  input  logic                      dec_ready,
  input  logic [31:0]               dec_value,
  output logic [ROB_SIZE_WIDTH:0]   tail_tag_out,
  output logic                      full_out,
  input  logic                      cdb_valid,
  input  logic [ROB_SIZE_WIDTH:0]   cdb_tag,
  input  logic [31:0]               cdb_value,
  input  logic                      cdb_mispredict,
  input  logic [31:0]               cdb_target,
  input  logic [ROB_SIZE_WIDTH:0]   query_tag1,
  input  logic [ROB_SIZE_WIDTH:0]   query_tag2,
  output logic                      query_ready1,
  output logic                      query_ready2,
  output logic [31:0]               query_value1,
  output logic [31:0]               query_value2,
  output logic                      commit_valid,
  output logic [REG_NUM_WIDTH-1:0]  commit_rd,
  output logic [31:0]               commit_value,
  output logic [ROB_SIZE_WIDTH:0]   commit_tag,
  output logic                      store_commit_valid,
  output logic [ROB_SIZE_WIDTH:0]   store_commit_tag,
  output logic                      flush_out,
  output logic [31:0]               flush_pc_out
);
  localparam int SIZE = 1 << ROB_SIZE_WIDTH;
  localparam int TW   = ROB_SIZE_WIDTH + 1;
  localparam logic [TW-1:0] NO_DEP   = '1;
  localparam logic [TW-1:0] CNT_FULL = TW'(SIZE);
  localparam logic [1:0] TYPE_BRANCH = 2'd1;
  localparam logic [1:0] TYPE_STORE  = 2'd2;

  logic [SIZE-1:0]          busy;
  logic [SIZE-1:0]          res_ready;
  logic [SIZE-1:0]          mispred;
  logic [1:0]               typ    [SIZE];
  logic [REG_NUM_WIDTH-1:0] rd     [SIZE];
  logic [31:0]              value  [SIZE];
  logic [31:0]              target [SIZE];

  logic [ROB_SIZE_WIDTH-1:0] head;
  logic [ROB_SIZE_WIDTH-1:0] tail;
  logic [ROB_SIZE_WIDTH-1:0] cdb_idx;
  logic [TW-1:0]             count;
  logic                      do_dispatch;
  logic                      do_retire;
  logic                      do_wb;

  assign full_out     = (count == CNT_FULL);
  assign tail_tag_out = {1'b0, tail};
  assign cdb_idx      = cdb_tag[ROB_SIZE_WIDTH-1:0];

  // A pending flush freezes dispatch, writeback and retirement for its cycle.
  assign do_dispatch = rdy_in && !flush_out && dec_valid && !full_out;
  assign do_retire   = rdy_in && !flush_out && busy[head] && res_ready[head];
  assign do_wb       = rdy_in && !flush_out && cdb_valid && !cdb_tag[TW-1] && busy[cdb_idx];

  function automatic logic lookup_ready(input logic [TW-1:0] tag);
    logic [ROB_SIZE_WIDTH-1:0] idx;
    idx = tag[ROB_SIZE_WIDTH-1:0];
    if (tag == NO_DEP) return 1'b1;
    return (cdb_valid && (cdb_tag == tag)) || (busy[idx] && res_ready[idx]);
  endfunction

  function automatic logic [31:0] lookup_value(input logic [TW-1:0] tag);
    logic [ROB_SIZE_WIDTH-1:0] idx;
    idx = tag[ROB_SIZE_WIDTH-1:0];
    if (tag == NO_DEP) return 32'd0;
    if (cdb_valid && (cdb_tag == tag)) return cdb_value;
    return value[idx];
  endfunction

  always_comb begin
    query_ready1 = lookup_ready(query_tag1);
    query_ready2 = lookup_ready(query_tag2);
    query_value1 = lookup_value(query_tag1);
    query_value2 = lookup_value(query_tag2);
  end

  // Entry payload: written on dispatch and writeback, never reset.
  always_ff @(posedge clk_in) begin
    if (do_dispatch) begin
      res_ready[tail] <= dec_ready;
      typ[tail]       <= dec_type;
      rd[tail]        <= dec_rd;
      value[tail]     <= dec_value;
      mispred[tail]   <= 1'b0;
    end
    if (do_wb) begin
      res_ready[cdb_idx] <= 1'b1;
      value[cdb_idx]     <= cdb_value;
      mispred[cdb_idx]   <= cdb_mispredict;
      target[cdb_idx]    <= cdb_target;
    end
  end

  // Control: pointers, occupancy and registered commit/flush pulses.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head               <= '0;
      tail               <= '0;
      count              <= '0;
      busy               <= '0;
      commit_valid       <= 1'b0;
      commit_rd          <= '0;
      commit_value       <= 32'd0;
      commit_tag         <= NO_DEP;
      store_commit_valid <= 1'b0;
      store_commit_tag   <= NO_DEP;
      flush_out          <= 1'b0;
      flush_pc_out       <= 32'd0;
    end else if (rdy_in) begin
      commit_valid       <= 1'b0;
      store_commit_valid <= 1'b0;
      flush_out          <= 1'b0;
      if (flush_out) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        busy  <= '0;
      end else begin
        if (do_retire) begin
          busy[head] <= 1'b0;
          head       <= head + 1'b1;
          if (typ[head] == TYPE_STORE) begin
            store_commit_valid <= 1'b1;
            store_commit_tag   <= {1'b0, head};
          end else if (rd[head] != '0) begin
            commit_valid <= 1'b1;
            commit_rd    <= rd[head];
            commit_value <= value[head];
            commit_tag   <= {1'b0, head};
          end
          if (typ[head] == TYPE_BRANCH && mispred[head]) begin
            flush_out    <= 1'b1;
            flush_pc_out <= target[head];
          end
        end
        if (do_dispatch) begin
          busy[tail] <= 1'b1;
          tail       <= tail + 1'b1;
        end
        count <= count + TW'(do_dispatch) - TW'(do_retire);
      end
    end
  end
endmodule

// File: tb/tb_rob_commit.sv
// Self-checking bench for rob_commit: directed scenarios plus randomized traffic
// compared against a program-order queue model of the reorder buffer.
module tb_rob_commit;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, dec_valid, dec_ready;
  logic [1:0]  dec_type;
  logic [4:0]  dec_rd;
  logic [31:0] dec_value;
  logic [3:0]  tail_tag_out;
  logic        full_out;
  logic        cdb_valid, cdb_mispredict;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_value, cdb_target;
  logic [3:0]  query_tag1, query_tag2;
  logic        query_ready1, query_ready2;
  logic [31:0] query_value1, query_value2;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  logic [3:0]  commit_tag;
  logic        store_commit_valid;
  logic [3:0]  store_commit_tag;
  logic        flush_out;
  logic [31:0] flush_pc_out;

  rob_commit #(.ROB_SIZE_WIDTH(3), .REG_NUM_WIDTH(5)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .dec_valid(dec_valid), .dec_type(dec_type), .dec_rd(dec_rd),
    .dec_ready(dec_ready), .dec_value(dec_value),
    .tail_tag_out(tail_tag_out), .full_out(full_out),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
    .query_tag1(query_tag1), .query_tag2(query_tag2),
    .query_ready1(query_ready1), .query_ready2(query_ready2),
    .query_value1(query_value1), .query_value2(query_value2),
    .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_value(commit_value), .commit_tag(commit_tag),
    .store_commit_valid(store_commit_valid), .store_commit_tag(store_commit_tag),
    .flush_out(flush_out), .flush_pc_out(flush_pc_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: in-flight instructions in program order.
  typedef struct {
    logic [3:0]  tag;
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic        rdy;
    logic [31:0] val;
    logic        mis;
    logic [31:0] tgt;
  } ent_t;
  ent_t q[$];
  int          next_tag = 0;
  logic        m_cv = 0, m_sv = 0, m_fl = 0;
  logic [4:0]  m_rd = 0;
  logic [31:0] m_val = 0, m_fpc = 0;
  logic [3:0]  m_ctag = 4'hF, m_stag = 4'hF;

  function automatic void model_step();
    int   n0;
    ent_t e;
    if (rst_in) begin
      q.delete(); next_tag = 0;
      m_cv = 0; m_rd = 0; m_val = 0; m_ctag = 4'hF;
      m_sv = 0; m_stag = 4'hF; m_fl = 0; m_fpc = 0;
      return;
    end
    if (!rdy_in) return;
    m_cv = 0; m_sv = 0;
    if (m_fl) begin
      q.delete(); next_tag = 0; m_fl = 0;
      return;
    end
    n0 = q.size();
    if (n0 > 0 && q[0].rdy) begin
      e = q.pop_front();
      if (e.typ == 2'd2) begin
        m_sv = 1; m_stag = e.tag;
      end else if (e.rd != 0) begin
        m_cv = 1; m_rd = e.rd; m_val = e.val; m_ctag = e.tag;
      end
      if (e.typ == 2'd1 && e.mis) begin
        m_fl = 1; m_fpc = e.tgt;
      end
    end
    if (cdb_valid) begin
      foreach (q[i]) if (q[i].tag == cdb_tag) begin
        q[i].rdy = 1; q[i].val = cdb_value; q[i].mis = cdb_mispredict; q[i].tgt = cdb_target;
      end
    end
    if (dec_valid && n0 < 8) begin
      e.tag = 4'(next_tag); e.typ = dec_type; e.rd = dec_rd; e.rdy = dec_ready;
      e.val = dec_value; e.mis = 0; e.tgt = 0;
      q.push_back(e);
      next_tag = (next_tag + 1) % 8;
    end
  endfunction

  function automatic void mquery(input logic [3:0] t, output logic r, output logic [31:0] v);
    r = 0; v = 0;
    if (t == 4'hF) begin r = 1; v = 0; return; end
    if (cdb_valid && cdb_tag == t) begin r = 1; v = cdb_value; return; end
    foreach (q[i]) if (q[i].tag == t && q[i].rdy) begin r = 1; v = q[i].val; end
  endfunction

  task automatic tick();
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
  endtask

  task automatic idle_inputs();
    dec_valid = 0; dec_type = 0; dec_rd = 0; dec_ready = 0; dec_value = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_value = 0; cdb_mispredict = 0; cdb_target = 0;
    query_tag1 = 4'hF; query_tag2 = 4'hF;
  endtask

  task automatic do_reset();
    idle_inputs(); rdy_in = 1; rst_in = 1;
    tick(); tick();
    rst_in = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (full_out !== 1'b0) begin n_errors++; $display("FAIL reset_full got=%b exp=0", full_out); end
    n_checks++; if (tail_tag_out !== 4'h0) begin n_errors++; $display("FAIL reset_tail got=%h exp=0", tail_tag_out); end
    n_checks++; if (commit_valid !== 1'b0) begin n_errors++; $display("FAIL reset_cv got=%b exp=0", commit_valid); end
    n_checks++; if (commit_tag !== 4'hF) begin n_errors++; $display("FAIL reset_ctag got=%h exp=f", commit_tag); end
    n_checks++; if (store_commit_tag !== 4'hF) begin n_errors++; $display("FAIL reset_stag got=%h exp=f", store_commit_tag); end
    n_checks++; if (flush_out !== 1'b0) begin n_errors++; $display("FAIL reset_flush got=%b exp=0", flush_out); end
    n_checks++; if (flush_pc_out !== 32'd0) begin n_errors++; $display("FAIL reset_fpc got=%h exp=0", flush_pc_out); end
  endtask

  task automatic test_single_commit();
    do_reset();
    dec_valid = 1; dec_type = 0; dec_rd = 5; dec_ready = 0; tick();
    idle_inputs(); tick();
    cdb_valid = 1; cdb_tag = 0; cdb_value = 32'hDEADBEEF; tick();
    idle_inputs(); #1;
    n_checks++; if (commit_valid !== 1'b0) begin n_errors++; $display("FAIL single_early got=%b exp=0", commit_valid); end
    tick(); #1;
    n_checks++; if (commit_valid !== 1'b1) begin n_errors++; $display("FAIL single_cv got=%b exp=1", commit_valid); end
    n_checks++; if (commit_rd !== 5'd5) begin n_errors++; $display("FAIL single_rd got=%0d exp=5", commit_rd); end
    n_checks++; if (commit_value !== 32'hDEADBEEF) begin n_errors++; $display("FAIL single_val got=%h exp=deadbeef", commit_value); end
    n_checks++; if (commit_tag !== 4'h0) begin n_errors++; $display("FAIL single_tag got=%h exp=0", commit_tag); end
    n_checks++; if (tail_tag_out !== 4'h1) begin n_errors++; $display("FAIL single_tail got=%h exp=1", tail_tag_out); end
    tick(); #1;
    n_checks++; if (commit_valid !== 1'b0) begin n_errors++; $display("FAIL single_pulse got=%b exp=0", commit_valid); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      dec_valid = 1; dec_type = 0; dec_rd = 5'(i + 1); dec_ready = 0; dec_value = 0; tick();
    end
    #1;
    n_checks++; if (full_out !== 1'b1) begin n_errors++; $display("FAIL full_set got=%b exp=1", full_out); end
    n_checks++; if (tail_tag_out !== 4'h0) begin n_errors++; $display("FAIL full_tailwrap got=%h exp=0", tail_tag_out); end
    dec_valid = 1; dec_rd = 20; dec_ready = 1; tick(); #1;
    n_checks++; if (tail_tag_out !== 4'h0) begin n_errors++; $display("FAIL full_ignore got=%h exp=0", tail_tag_out); end
    n_checks++; if (full_out !== 1'b1) begin n_errors++; $display("FAIL full_hold got=%b exp=1", full_out); end
    idle_inputs(); cdb_valid = 1; cdb_tag = 0; cdb_value = 32'h55; tick();
    idle_inputs(); dec_valid = 1; dec_rd = 21; tick(); #1;
    n_checks++; if (commit_valid !== 1'b1 || commit_tag !== 4'h0 || commit_rd !== 5'd1)
      begin n_errors++; $display("FAIL full_retire got=%b/%h/%0d exp=1/0/1", commit_valid, commit_tag, commit_rd); end
    n_checks++; if (full_out !== 1'b0 || tail_tag_out !== 4'h0)
      begin n_errors++; $display("FAIL full_reject_on_retire got=%b/%h exp=0/0", full_out, tail_tag_out); end
    tick(); #1;
    n_checks++; if (full_out !== 1'b1 || tail_tag_out !== 4'h1)
      begin n_errors++; $display("FAIL full_accept got=%b/%h exp=1/1", full_out, tail_tag_out); end
    idle_inputs();
  endtask

  task automatic test_flush();
    do_reset();
    dec_valid = 1; dec_type = 1; dec_rd = 1; dec_ready = 0; tick();
    dec_type = 0; dec_rd = 2; dec_ready = 1; dec_value = 5; tick();
    dec_rd = 3; dec_ready = 0; tick();
    idle_inputs(); cdb_valid = 1; cdb_tag = 0; cdb_value = 32'h44;
    cdb_mispredict = 1; cdb_target = 32'h100; tick();
    idle_inputs(); tick(); #1;
    n_checks++; if (flush_out !== 1'b1 || flush_pc_out !== 32'h100)
      begin n_errors++; $display("FAIL flush_pulse got=%b/%h exp=1/100", flush_out, flush_pc_out); end
    n_checks++; if (commit_valid !== 1'b1 || commit_rd !== 5'd1 || commit_value !== 32'h44 || commit_tag !== 4'h0)
      begin n_errors++; $display("FAIL flush_branch_commit got=%b/%0d/%h/%h exp=1/1/44/0", commit_valid, commit_rd, commit_value, commit_tag); end
    dec_valid = 1; dec_rd = 7; dec_ready = 1; tick(); #1;
    n_checks++; if (flush_out !== 1'b0) begin n_errors++; $display("FAIL flush_one_cycle got=%b exp=0", flush_out); end
    n_checks++; if (tail_tag_out !== 4'h0 || full_out !== 1'b0)
      begin n_errors++; $display("FAIL flush_clear got=%h/%b exp=0/0", tail_tag_out, full_out); end
    n_checks++; if (commit_valid !== 1'b0) begin n_errors++; $display("FAIL flush_no_commit got=%b exp=0", commit_valid); end
    idle_inputs(); tick(); tick(); #1;
    n_checks++; if (commit_valid !== 1'b0) begin n_errors++; $display("FAIL flush_younger got=%b exp=0", commit_valid); end
  endtask

  task automatic test_query();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      dec_valid = 1; dec_type = 0; dec_rd = 5'(i + 1); dec_ready = 0; tick();
    end
    idle_inputs();
    query_tag1 = 2; query_tag2 = 4'hF; cdb_valid = 1; cdb_tag = 2; cdb_value = 7; #1;
    n_checks++; if (query_ready1 !== 1'b1 || query_value1 !== 32'd7)
      begin n_errors++; $display("FAIL query_bypass got=%b/%h exp=1/7", query_ready1, query_value1); end
    n_checks++; if (query_ready2 !== 1'b1 || query_value2 !== 32'd0)
      begin n_errors++; $display("FAIL query_nodep got=%b/%h exp=1/0", query_ready2, query_value2); end
    cdb_valid = 0; #1;
    n_checks++; if (query_ready1 !== 1'b0) begin n_errors++; $display("FAIL query_notready got=%b exp=0", query_ready1); end
    cdb_valid = 1; tick(); cdb_valid = 0; #1;
    n_checks++; if (query_ready1 !== 1'b1 || query_value1 !== 32'd7)
      begin n_errors++; $display("FAIL query_stored got=%b/%h exp=1/7", query_ready1, query_value1); end
    idle_inputs();
  endtask

  task automatic test_store_and_hold();
    do_reset();
    dec_valid = 1; dec_type = 2; dec_rd = 0; dec_ready = 0; tick();
    idle_inputs(); cdb_valid = 1; cdb_tag = 0; cdb_value = 32'h1234; tick();
    idle_inputs(); dec_valid = 1; dec_type = 0; dec_rd = 9; dec_ready = 1; dec_value = 32'hAB; tick(); #1;
    n_checks++; if (store_commit_valid !== 1'b1 || store_commit_tag !== 4'h0 || commit_valid !== 1'b0)
      begin n_errors++; $display("FAIL store_commit got=%b/%h/%b exp=1/0/0", store_commit_valid, store_commit_tag, commit_valid); end
    rdy_in = 0; dec_rd = 10; cdb_valid = 1; cdb_tag = 1; cdb_value = 32'hEE;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      n_checks++; if (tail_tag_out !== 4'h2 || commit_valid !== 1'b0 || store_commit_valid !== 1'b1)
        begin n_errors++; $display("FAIL hold_%0d got=%h/%b/%b exp=2/0/1", i, tail_tag_out, commit_valid, store_commit_valid); end
    end
    rdy_in = 1; idle_inputs(); tick(); #1;
    n_checks++; if (commit_valid !== 1'b1 || commit_rd !== 5'd9 || commit_value !== 32'hAB || commit_tag !== 4'h1 || store_commit_valid !== 1'b0)
      begin n_errors++; $display("FAIL hold_resume got=%b/%0d/%h/%h/%b exp=1/9/ab/1/0", commit_valid, commit_rd, commit_value, commit_tag, store_commit_valid); end
  endtask

  task automatic test_random();
    logic er1, er2;
    logic [31:0] ev1, ev2;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rdy_in = ($urandom_range(9) != 0);
      dec_valid = 1'($urandom_range(1));
      dec_type = 2'($urandom_range(2));
      dec_rd = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31));
      dec_ready = ($urandom_range(3) == 0);
      dec_value = $urandom;
      cdb_valid = 1'($urandom_range(1));
      if (q.size() > 0 && $urandom_range(3) != 0) cdb_tag = q[$urandom_range(q.size() - 1)].tag;
      else cdb_tag = 4'($urandom_range(7));
      cdb_value = $urandom;
      cdb_mispredict = ($urandom_range(15) == 0);
      cdb_target = $urandom;
      query_tag1 = ($urandom_range(7) == 0) ? 4'hF : 4'($urandom_range(7));
      query_tag2 = ($urandom_range(7) == 0) ? 4'hF : 4'($urandom_range(7));
      #1;
      mquery(query_tag1, er1, ev1);
      mquery(query_tag2, er2, ev2);
      n_checks++; if (full_out !== (q.size() == 8)) begin n_errors++; $display("FAIL rnd_full c=%0d got=%b exp=%b", c, full_out, q.size() == 8); end
      n_checks++; if (tail_tag_out !== 4'(next_tag)) begin n_errors++; $display("FAIL rnd_tail c=%0d got=%h exp=%h", c, tail_tag_out, 4'(next_tag)); end
      n_checks++; if (query_ready1 !== er1) begin n_errors++; $display("FAIL rnd_qr1 c=%0d got=%b exp=%b", c, query_ready1, er1); end
      n_checks++; if (query_ready2 !== er2) begin n_errors++; $display("FAIL rnd_qr2 c=%0d got=%b exp=%b", c, query_ready2, er2); end
      if (er1) begin n_checks++; if (query_value1 !== ev1) begin n_errors++; $display("FAIL rnd_qv1 c=%0d got=%h exp=%h", c, query_value1, ev1); end end
      if (er2) begin n_checks++; if (query_value2 !== ev2) begin n_errors++; $display("FAIL rnd_qv2 c=%0d got=%h exp=%h", c, query_value2, ev2); end end
      n_checks++; if (commit_valid !== m_cv) begin n_errors++; $display("FAIL rnd_cv c=%0d got=%b exp=%b", c, commit_valid, m_cv); end
      if (m_cv) begin
        n_checks++; if (commit_rd !== m_rd || commit_value !== m_val || commit_tag !== m_ctag)
          begin n_errors++; $display("FAIL rnd_commit c=%0d got=%0d/%h/%h exp=%0d/%h/%h", c, commit_rd, commit_value, commit_tag, m_rd, m_val, m_ctag); end
      end
      n_checks++; if (store_commit_valid !== m_sv) begin n_errors++; $display("FAIL rnd_sv c=%0d got=%b exp=%b", c, store_commit_valid, m_sv); end
      if (m_sv) begin
        n_checks++; if (store_commit_tag !== m_stag) begin n_errors++; $display("FAIL rnd_stag c=%0d got=%h exp=%h", c, store_commit_tag, m_stag); end
      end
      n_checks++; if (flush_out !== m_fl) begin n_errors++; $display("FAIL rnd_flush c=%0d got=%b exp=%b", c, flush_out, m_fl); end
      if (m_fl) begin
        n_checks++; if (flush_pc_out !== m_fpc) begin n_errors++; $display("FAIL rnd_fpc c=%0d got=%h exp=%h", c, flush_pc_out, m_fpc); end
      end
      tick();
    end
    idle_inputs(); rdy_in = 1;
  endtask

  initial begin
    idle_inputs(); rdy_in = 1; rst_in = 1;
    @(negedge clk_in);
    test_reset();
    test_single_commit();
    test_full_wrap();
    test_flush();
    test_query();
    test_store_and_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
